// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with load, shifts, rotates, clear and drain counter
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic [CW-1:0]    cnt,
  output logic             drained
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_inc;

  always_comb begin
    q_next   = q;
    cnt_next = cnt;
    // Counted shifts saturate so surrounding FSMs can hold on drained.
    cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    case (mode)
      MODE_HOLD: ;
      MODE_LOAD: begin
        q_next   = par_in;
        cnt_next = '0;
      end
      MODE_SHL: begin
        q_next   = {q[WIDTH-2:0], ser_in_l};
        cnt_next = cnt_inc;
      end
      MODE_SHR: begin
        q_next   = {ser_in_r, q[WIDTH-1:1]};
        cnt_next = cnt_inc;
      end
      MODE_ROL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR: q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR: begin
        q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
        cnt_next = cnt_inc;
      end
      MODE_CLR: begin
        q_next   = '0;
        cnt_next = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= RESET_VAL;
      cnt <= '0;
    end else if (en) begin
      q   <= q_next;
      cnt <= cnt_next;
    end
  end

  assign ser_out_msb = q[WIDTH-1];
  assign ser_out_lsb = q[0];
  assign drained     = (cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg against an arithmetic model
module tb_univ_shift_reg;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] par_in = 8'd0;
  logic       ser_in_l = 1'b0;
  logic       ser_in_r = 1'b0;
  logic [7:0] q;
  logic       ser_out_msb;
  logic       ser_out_lsb;
  logic [3:0] cnt;
  logic       drained;

  int errors = 0;
  int checks = 0;
  int m_q = 0;
  int m_cnt = 0;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .par_in(par_in),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .q(q),
    .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb),
    .cnt(cnt), .drained(drained)
  );

  always #5 clk = ~clk;

  // Reference model: register value as an integer 0..255, shifts as multiply/divide by 2.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] p, input logic sl, input logic sr);
    int nq;
    int nc;
    @(negedge clk);
    rst = r; en = e; mode = m; par_in = p; ser_in_l = sl; ser_in_r = sr;
    @(posedge clk);
    nq = m_q;
    nc = m_cnt;
    if (r) begin
      nq = int'(RV);
      nc = 0;
    end else if (e) begin
      case (m)
        3'd1: begin nq = int'(p); nc = 0; end
        3'd2: begin nq = (m_q * 2) % 256 + int'(sl); nc = (m_cnt < W) ? m_cnt + 1 : W; end
        3'd3: begin nq = m_q / 2 + int'(sr) * 128; nc = (m_cnt < W) ? m_cnt + 1 : W; end
        3'd4: nq = (m_q * 2) % 256 + m_q / 128;
        3'd5: nq = m_q / 2 + (m_q % 2) * 128;
        3'd6: begin nq = m_q / 2 + ((m_q >= 128) ? 128 : 0); nc = (m_cnt < W) ? m_cnt + 1 : W; end
        3'd7: begin nq = 0; nc = 0; end
        default: ;
      endcase
    end
    m_q = nq;
    m_cnt = nc;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 3'd0, 8'h00, 0, 0);
    checks++;
    if (q !== 8'hA5) begin errors++; $display("FAIL reset_q: got %h want a5", q); end
    checks++;
    if (cnt !== 4'd0 || drained !== 1'b0) begin
      errors++; $display("FAIL reset_cnt: got cnt=%0d drained=%b want 0/0", cnt, drained);
    end
    checks++;
    if (ser_out_msb !== 1'b1 || ser_out_lsb !== 1'b1) begin
      errors++; $display("FAIL reset_ser: got msb=%b lsb=%b want 1/1", ser_out_msb, ser_out_lsb);
    end
  endtask

  task automatic test_serialise();
    logic [7:0] exp_bits;
    exp_bits = 8'b1011_0100;
    step(0, 1, 3'd1, 8'hB4, 1, 1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ser_out_msb !== exp_bits[7-i]) begin
        errors++; $display("FAIL ser_msb_%0d: got %b want %b", i, ser_out_msb, exp_bits[7-i]);
      end
      step(0, 1, 3'd2, 8'hFF, 0, 1);
    end
    checks++;
    if (q !== 8'h00 || cnt !== 4'd8 || drained !== 1'b1) begin
      errors++; $display("FAIL ser_done: got q=%h cnt=%0d drained=%b want 00/8/1", q, cnt, drained);
    end
    step(0, 1, 3'd2, 8'h00, 0, 0);
    checks++;
    if (cnt !== 4'd8 || drained !== 1'b1) begin
      errors++; $display("FAIL ser_saturate: got cnt=%0d drained=%b want 8/1", cnt, drained);
    end
  endtask

  task automatic test_deserialise();
    logic [7:0] bits;
    bits = 8'b0101_0011;
    step(0, 1, 3'd7, 8'hFF, 1, 1);
    checks++;
    if (q !== 8'h00 || cnt !== 4'd0 || drained !== 1'b0) begin
      errors++; $display("FAIL clr: got q=%h cnt=%0d drained=%b want 00/0/0", q, cnt, drained);
    end
    for (int i = 0; i < 8; i++) step(0, 1, 3'd3, 8'h00, 1, bits[i]);
    checks++;
    if (q !== 8'h53 || cnt !== 4'd8 || drained !== 1'b1) begin
      errors++; $display("FAIL deser: got q=%h cnt=%0d drained=%b want 53/8/1", q, cnt, drained);
    end
  endtask

  task automatic test_rotate_asr();
    step(0, 1, 3'd1, 8'h81, 0, 0);
    step(0, 1, 3'd4, 8'h00, 0, 0);
    checks++;
    if (q !== 8'h03 || cnt !== 4'd0) begin
      errors++; $display("FAIL rol: got q=%h cnt=%0d want 03/0", q, cnt);
    end
    step(0, 1, 3'd5, 8'h00, 1, 1);
    checks++;
    if (q !== 8'h81 || cnt !== 4'd0) begin
      errors++; $display("FAIL ror: got q=%h cnt=%0d want 81/0", q, cnt);
    end
    step(0, 1, 3'd6, 8'h00, 0, 0);
    checks++;
    if (q !== 8'hC0 || cnt !== 4'd1) begin
      errors++; $display("FAIL asr1: got q=%h cnt=%0d want c0/1", q, cnt);
    end
    step(0, 1, 3'd6, 8'h00, 0, 0);
    checks++;
    if (q !== 8'hE0 || cnt !== 4'd2) begin
      errors++; $display("FAIL asr2: got q=%h cnt=%0d want e0/2", q, cnt);
    end
  endtask

  task automatic test_enable_priority();
    step(0, 1, 3'd1, 8'h3C, 0, 0);
    step(0, 0, 3'd1, 8'hFF, 1, 1);
    checks++;
    if (q !== 8'h3C) begin errors++; $display("FAIL en_hold: got %h want 3c", q); end
    step(0, 1, 3'd2, 8'h00, 1, 0);
    step(1, 1, 3'd1, 8'hFF, 1, 1);
    checks++;
    if (q !== 8'hA5 || cnt !== 4'd0) begin
      errors++; $display("FAIL rst_prio: got q=%h cnt=%0d want a5/0", q, cnt);
    end
  endtask

  task automatic test_mid_reset();
    step(0, 1, 3'd1, 8'hF0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd2, 8'h00, 0, 0);
    checks++;
    if (cnt !== 4'd3 || q !== 8'h80) begin
      errors++; $display("FAIL mid_pre: got q=%h cnt=%0d want 80/3", q, cnt);
    end
    step(1, 1, 3'd2, 8'h00, 1, 0);
    checks++;
    if (q !== 8'hA5 || cnt !== 4'd0 || drained !== 1'b0) begin
      errors++; $display("FAIL mid_rst: got q=%h cnt=%0d drained=%b want a5/0/0", q, cnt, drained);
    end
    step(0, 1, 3'd2, 8'h00, 1, 0);
    checks++;
    if (cnt !== 4'd1 || q !== 8'h4B) begin
      errors++; $display("FAIL mid_post: got q=%h cnt=%0d want 4b/1", q, cnt);
    end
  endtask

  task automatic test_random();
    logic [2:0] m;
    logic       r;
    logic       e;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 7) != 0);
      // Bias toward counted shifts so saturation and drained are exercised.
      m = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7))
                                      : (($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3);
      if ($urandom_range(0, 19) == 0) m = 3'd1;
      step(r, e, m, 8'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (q !== 8'(m_q) || cnt !== 4'(m_cnt) || drained !== (m_cnt == W) ||
          ser_out_msb !== (m_q >= 128) || ser_out_lsb !== (m_q % 2 == 1)) begin
        errors++;
        $display("FAIL rand_%0d: got q=%h cnt=%0d drained=%b msb=%b lsb=%b want q=%h cnt=%0d drained=%b",
                 i, q, cnt, drained, ser_out_msb, ser_out_lsb, 8'(m_q), m_cnt, (m_cnt == W));
      end
    end
  endtask

  initial begin
    test_reset();
    test_serialise();
    test_deserialise();
    test_rotate_asr();
    test_enable_priority();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: WIDTH-bit storage with parallel load, logical/arithmetic shifts, rotates, clear and hold, selected per cycle by a mode code. It extends the team's 4-bit parallel-in/parallel-out register into a general serialiser/deserialiser building block. A saturating shift counter with a `drained` flag lets surrounding FSMs know when a loaded word has been fully shifted out. Used in serial links, bit-banged interfaces and datapath staging.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, 0, value of `q` after reset (WIDTH bits).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high; priority over all other inputs.
- en  in  1  cycle enable; when 0 all state holds regardless of `mode`.
- mode  in  3  operation select (see Operation).
- par_in  in  WIDTH  parallel load data.
- ser_in_l  in  1  bit entering q[0] on shift-left.
- ser_in_r  in  1  bit entering q[WIDTH-1] on logical shift-right.
- q  out  WIDTH  register contents (parallel out).
- ser_out_msb  out  1  equals q[WIDTH-1] (bit leaving on shift-left).
- ser_out_lsb  out  1  equals q[0] (bit leaving on shift-right).
- cnt  out  CW  shifts since last load/clear, CW = $clog2(WIDTH+1); saturates at WIDTH.
- drained  out  1  high when cnt == WIDTH.

## Operation
- Mode codes (applied only when en=1, rst=0):
  - 000 HOLD: q, cnt unchanged.
  - 001 LOAD: q <= par_in; cnt <= 0.
  - 010 SHL: q <= {q[WIDTH-2:0], ser_in_l}; cnt increments.
  - 011 SHR: q <= {ser_in_r, q[WIDTH-1:1]}; cnt increments.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; cnt unchanged.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}; cnt unchanged.
  - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; cnt increments.
  - 111 CLR: q <= 0 (not RESET_VAL); cnt <= 0.
- cnt increment saturates: at cnt == WIDTH further shifts still move q but cnt stays WIDTH.
- drained is combinational decode of registered cnt; no separate state.
- ser_out_msb / ser_out_lsb are direct taps of registered q; no extra flop.
- No illegal modes; all 8 codes defined.
- Serial inputs ignored in every mode except their own shift (ser_in_l only in SHL, ser_in_r only in SHR).

## Timing
- Reset: on rising clk with rst=1 → q = RESET_VAL, cnt = 0, drained = 0, ser_out_* reflect RESET_VAL; effective next cycle.
- rst mid-operation (e.g. during a shift sequence) discards the sequence; no partial update that cycle.
- All operations: 1-cycle latency; result visible on q the cycle after the sampling edge.
- rst=1 and en=1 same cycle: reset wins. en=0: mode, par_in, serial inputs ignored.
- LOAD followed immediately by SHL on next cycle: shift operates on loaded value; cnt goes 0 → 1.
- drained asserts the cycle after the WIDTH-th counted shift following a load/clear; deasserts the cycle after the next LOAD/CLR/rst.
- Back-to-back mode changes every cycle are legal; no turnaround cycles.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5, rst=1 one cycle → q=8'hA5, cnt=0, drained=0, ser_out_msb=1, ser_out_lsb=1.
- Load/serialise: LOAD 8'hB4, then 8×SHL with ser_in_l=0 → ser_out_msb sequence 1,0,1,1,0,1,0,0 before each shift; q=8'h00, cnt=8, drained=1; 9th SHL keeps cnt=8.
- Deserialise: CLR, then 8×SHR with ser_in_r bits 1,1,0,0,1,0,1,0 → q=8'h53, cnt=8, drained=1.
- Rotate/ASR: LOAD 8'h81; ROL → 8'h03, ROR → 8'h81, cnt=0 throughout; ASR → 8'hC0, cnt=1; ASR → 8'hE0, cnt=2.
- Enable/priority: q=8'h3C, en=0 with mode=LOAD par_in=8'hFF → q stays 8'h3C; en=1, rst=1, mode=LOAD → q=RESET_VAL, cnt=0.
- Mid-sequence reset: LOAD 8'hF0, 3×SHL (cnt=3), rst → q=RESET_VAL, cnt=0, drained=0; subsequent SHL counts from 1.
